// File: rtl/uart_alu_ctrl.sv
// Frame controller between a UART rx/tx pair and an ALU: collects A, B and an opcode,
// drives the ALU, and sends the result (or an error code) back as a single byte.
module uart_alu_ctrl #(
  parameter int          NB_DATA    = 8,
  parameter int          NB_OP      = 6,
  parameter int          TIMEOUT    = 100000,
  parameter int          NB_TIMEOUT = 17,
  parameter logic [7:0]  ERR_CODE   = 8'hFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;

  // The counter value that ends a stalled frame. It is decoded on the value about to be
  // loaded, so o_err and the drop of o_busy land exactly TIMEOUT cycles after the last byte.
  localparam logic [NB_TIMEOUT-1:0] CNT_TERM = NB_TIMEOUT'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [NB_DATA-1:0]      data_a_q, data_a_d;
  logic [NB_DATA-1:0]      data_b_q, data_b_d;
  logic [NB_OP-1:0]        op_q, op_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [NB_TIMEOUT-1:0]   cnt_q, cnt_d;
  logic [NB_TIMEOUT-1:0]   cnt_inc;
  logic                    cnt_expired;

  function automatic logic op_is_valid(input logic [7:0] op_byte);
    logic ok;
    ok = 1'b0;
    if (op_byte[7:6] == 2'b00) begin
      case (op_byte[5:0])
        6'b100000, 6'b100010, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b000011, 6'b000010: ok = 1'b1;
        default:                                    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  assign cnt_inc     = cnt_q + 1'b1;
  assign cnt_expired = (cnt_inc == CNT_TERM);

  // NOTE: every signal assigned in this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    cnt_d      = '0;

    case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          data_a_d = NB_DATA'(i_rx_data);
          state_d  = WAIT_B;
        end
      end

      WAIT_B: begin
        if (i_rx_done) begin
          data_b_d = NB_DATA'(i_rx_data);
          state_d  = WAIT_OP;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_OP: begin
        if (i_rx_done) begin
          if (op_is_valid(i_rx_data)) begin
            op_d    = NB_OP'(i_rx_data[5:0]);
            state_d = EXEC;
          end else begin
            tx_data_d = ERR_CODE;
            err_d     = 1'b1;
            state_d   = SEND;
          end
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // The start request is registered, so the result path raises it here and it is
      // seen during SEND; the error path enters SEND directly and raises it from there.
      EXEC: begin
        tx_data_d  = 8'(i_alu_result);
        tx_start_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        tx_start_d = ~tx_start_q;
        state_d    = WAIT_TX;
      end

      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed frames, expected transmits and error pulses are
// queued with their due cycle and compared by an independent monitor.
module tb_uart_alu_ctrl;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] data_a, data_b, tx_data;
  logic [5:0] op;
  logic       tx_start, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
  } tx_exp_t;

  tx_exp_t    tx_q[$];
  int         err_q[$];
  logic [5:0] exp_op;

  uart_alu_ctrl #(
    .NB_DATA   (8),
    .NB_OP     (6),
    .TIMEOUT   (TIMEOUT),
    .NB_TIMEOUT(5),
    .ERR_CODE  (8'hFF)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_alu_result(alu_result),
    .i_tx_done   (tx_done),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op        (op),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .o_busy      (busy),
    .o_err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU in the environment, fed from the controller's operand outputs.
  always_comb begin
    case (op)
      6'b100000: alu_result = data_a + data_b;
      6'b100010: alu_result = data_a - data_b;
      6'b100100: alu_result = data_a & data_b;
      6'b100101: alu_result = data_a | data_b;
      6'b100110: alu_result = data_a ^ data_b;
      6'b100111: alu_result = ~(data_a | data_b);
      6'b000011: alu_result = 8'($signed(data_a) >>> data_b);
      6'b000010: alu_result = data_a >> data_b;
      default:   alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_start: got tx_data %0h with no transmit expected (cycle %0d)",
                 tx_data, cyc);
      end else begin
        tx_exp_t e;
        e = tx_q.pop_front();
        check("tx_start_cycle", cyc, e.due);
        check("tx_data", tx_data, e.data);
        check("tx_data_a", data_a, e.a);
        check("tx_data_b", data_b, e.b);
        check("tx_op", op, e.op);
      end
    end
    if (err === 1'b1) begin
      if (err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_err: got err pulse with none expected (cycle %0d)", cyc);
      end else begin
        check("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic push_tx(input int due, input logic [7:0] d, input logic [7:0] a,
                         input logic [7:0] b, input logic [5:0] o);
    tx_exp_t e;
    e.due  = due;
    e.data = d;
    e.a    = a;
    e.b    = b;
    e.op   = o;
    tx_q.push_back(e);
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [7:0] exp_tx, input bit valid);
    send_byte(a);
    check("busy_after_a", busy, 1);
    check("data_a_latched", data_a, a);
    send_byte(b);
    if (valid) exp_op = opb[5:0];
    else       err_q.push_back(cyc + 1);
    push_tx(cyc + 2, exp_tx, a, b, exp_op);
    send_byte(opb);
  endtask

  task automatic finish_tx();
    idle(2);
    check("busy_in_wait_tx", busy, 1);
    pulse_tx_done();
    check("busy_after_tx_done", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_a"}, data_a, 0);
    check({tag, "_data_b"}, data_b, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic reset_dut(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_op = 6'h00;
    check_all_zero(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    exp_op  = 6'h00;
    idle(2);
    reset = 1'b0;
    check_all_zero("reset");

    // ADD, SUB, then a back-to-back SRA frame.
    do_frame(8'h05, 8'h03, 8'h20, 8'h08, 1'b1);
    finish_tx();
    do_frame(8'h0F, 8'h01, 8'h22, 8'h0E, 1'b1);
    finish_tx();
    do_frame(8'hF0, 8'h02, 8'h03, 8'hFC, 1'b1);
    finish_tx();

    // Invalid opcode: error code sent, opcode register keeps SRA.
    do_frame(8'h01, 8'h02, 8'h3F, 8'hFF, 1'b0);
    finish_tx();
    check("op_kept_after_invalid", op, 6'b000011);

    // Stalled frame after one byte.
    p = cyc;
    err_q.push_back(p + TIMEOUT);
    send_byte(8'h11);
    idle(TIMEOUT - 2);
    check("busy_before_timeout", busy, 1);
    idle(1);
    check("busy_at_timeout", busy, 0);
    check("data_a_held_after_timeout", data_a, 8'h11);
    do_frame(8'h0A, 8'h05, 8'h26, 8'h0F, 1'b1);
    finish_tx();

    // Second byte lands exactly on the terminal count and is accepted.
    p = cyc;
    send_byte(8'h33);
    idle(TIMEOUT - 2);
    check("terminal_cycle_reached", cyc, p + TIMEOUT - 1);
    send_byte(8'h44);
    check("terminal_byte_data_b", data_b, 8'h44);
    check("terminal_byte_busy", busy, 1);
    exp_op = 6'b100000;
    push_tx(cyc + 2, 8'h77, 8'h33, 8'h44, exp_op);
    send_byte(8'h20);
    finish_tx();

    // A byte arriving during WAIT_TX is dropped.
    do_frame(8'h09, 8'h03, 8'h24, 8'h01, 1'b1);
    idle(2);
    send_byte(8'h55);
    check("wait_tx_byte_ignored_a", data_a, 8'h09);
    check("wait_tx_byte_busy", busy, 1);
    pulse_tx_done();
    check("busy_after_ignored_byte", busy, 0);
    do_frame(8'h07, 8'h01, 8'h25, 8'h07, 1'b1);
    finish_tx();

    // Reset in WAIT_OP, then in WAIT_TX; each followed by a quiet window.
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset_dut("rst_wait_op");
    idle(3);
    do_frame(8'h02, 8'h03, 8'h27, 8'hFC, 1'b1);
    idle(2);
    reset_dut("rst_wait_tx");
    idle(3);
    check("busy_after_rst_wait_tx", busy, 0);
    do_frame(8'h40, 8'h03, 8'h02, 8'h08, 1'b1);
    finish_tx();

    idle(3);
    check("tx_queue_drained", tx_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Controller that sits between the UART receiver/transmitter pair and the ALU. It collects a three-byte command frame from the receiver: operand A, then operand B, then opcode. It drives the ALU operand and opcode inputs, captures the ALU result and schedules a single transmit of that result byte back through the UART. It validates opcodes, aborts stalled frames with an inter-byte timeout, and reports errors.

## Interface
Parameters:
- NB_DATA, 8, operand/result width; equals the UART byte width.
- NB_OP, 6, ALU opcode width.
- TIMEOUT, 100000, maximum clock cycles allowed between bytes of one frame.
- NB_TIMEOUT, 17, timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT.
- ERR_CODE, 8'hFF, byte transmitted when a frame carries an invalid opcode.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte; valid only while i_rx_done is high.
- i_rx_done  in  1  one-cycle pulse from the UART receiver.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done  in  1  one-cycle pulse from the UART transmitter when a byte has been fully sent.
- o_data_a  out  NB_DATA  ALU operand A (registered).
- o_data_b  out  NB_DATA  ALU operand B (registered).
- o_op  out  NB_OP  ALU opcode (registered).
- o_tx_start  out  1  one-cycle transmit request.
- o_tx_data  out  8  byte to transmit; stable from the o_tx_start cycle until i_tx_done.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  one-cycle pulse on an invalid opcode or a timeout.

## Operation
- Valid opcodes (o_op encoding):
  - ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101.
  - XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.
  - An opcode byte is valid only if bits [7:6] are 0 and bits [5:0] match the list above.
- FSM states: IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- IDLE: on i_rx_done, latch the byte into o_data_a, go to WAIT_B.
- WAIT_B: on i_rx_done, latch into o_data_b, go to WAIT_OP.
- WAIT_OP:
  - on i_rx_done with a valid opcode: latch [5:0] into o_op, go to EXEC.
  - on i_rx_done with an invalid opcode: load ERR_CODE into o_tx_data, pulse o_err, go to SEND; o_op is unchanged.
- EXEC: for one cycle, load i_alu_result[7:0] into o_tx_data, then go to SEND.
- SEND: o_tx_start=1 for exactly this cycle, then go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to IDLE.
- i_rx_done is ignored in EXEC, SEND and WAIT_TX; those bytes are dropped and never start a new frame.
- i_tx_done is ignored outside WAIT_TX.
- o_data_a, o_data_b and o_op hold their values until overwritten by the next frame; they are never cleared by a timeout.
- Timeout counter:
  - cleared on every accepted byte and while in IDLE, EXEC, SEND and WAIT_TX.
  - increments each cycle in WAIT_B and WAIT_OP.
  - when it equals TIMEOUT-1: go to IDLE, pulse o_err, no transmit.
- Simultaneous events: i_rx_done in the same cycle as the timeout terminal count means the byte is accepted and no timeout occurs.
- Reset, including mid-frame or mid-transmit:
  - state returns to IDLE.
  - all outputs go to 0: o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_err.
  - counter is cleared.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A byte accepted on cycle N appears on the corresponding output at cycle N+1; the state also changes at N+1.
- Valid opcode pulse at cycle N:
  - cycle N+1: EXEC, with o_op valid so the ALU result settles.
  - cycle N+2: o_tx_start=1 and o_tx_data = result.
- Invalid opcode pulse at cycle N:
  - o_err=1 at N+1.
  - o_tx_start=1 at N+2 with o_tx_data=ERR_CODE.
- o_busy rises the cycle after the first byte is accepted. It falls the cycle after i_tx_done, or the cycle after a timeout.
- A new frame can begin on the cycle o_busy is back to 0.
- Timeout: after the last accepted byte at cycle N with no further i_rx_done, o_err=1 and o_busy=0 at cycle N+TIMEOUT.

## Test plan
- Reset, then bytes 0x05, 0x03, 0x20, bench ALU model ADD: o_data_a=0x05, o_data_b=0x03, o_op=6'b100000; o_tx_start pulses 2 cycles after the third i_rx_done with o_tx_data=0x08; o_busy clears after i_tx_done.
- Bytes 0x0F, 0x01, 0x22 (SUB): o_tx_data=0x0E. Back-to-back frame 0xF0, 0x02, 0x03 (SRA) started right after o_busy falls: o_tx_data=0xFC.
- Bytes 0x01, 0x02, 0x3F (invalid): o_err pulses once; o_tx_start with o_tx_data=0xFF; o_op keeps its previous value.
- TIMEOUT=16: single byte 0x11, then idle: o_err pulses and o_busy=0 exactly 16 cycles after the byte pulse, no o_tx_start. A following full frame completes correctly. Also drive a byte exactly on the terminal count: it is accepted with no o_err.
- During WAIT_TX, inject i_rx_done with 0x55: the byte is ignored; the next frame's o_data_a comes from the next byte after o_busy=0.
- Assert i_reset for one cycle in WAIT_OP and again in WAIT_TX: all outputs are 0 the next cycle, no o_tx_start is issued, and a subsequent frame works.
